// File: rtl/serial_pkg.sv
// Shared types and helpers for the parametrised serial receiver.
package serial_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Bits needed to hold values 0..value-1 (minimum 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/serial_baud_cnt.sv
// Bit-period counter: emits a one-cycle tick at the half or full bit point,
// then restarts from zero.
module serial_baud_cnt
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic i_clk,
   input  logic i_srst,
   input  logic i_clear,
   input  logic i_enable,
   input  logic i_half,
   output logic o_tick
);
   localparam int BW = clog2(CLKS_PER_BIT);

   logic [BW-1:0] r_cnt;
   logic [BW-1:0] w_limit;

   assign w_limit = i_half ? BW'(CLKS_PER_BIT / 2 - 1) : BW'(CLKS_PER_BIT - 1);
   assign o_tick  = i_enable && (r_cnt == w_limit);

   always_ff @(posedge i_clk) begin
      if (i_srst || i_clear || o_tick)
         r_cnt <= '0;
      else if (i_enable)
         r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/serial_rx_param.sv
// UART-style receiver with configurable width, parity and stop bits, an input
// synchroniser and a valid/ready output register with error reporting.
module serial_rx_param
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = PAR_NONE,
   parameter int STOP_BITS    = 1,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 m_clock,
   input  logic                 p_reset,
   input  logic                 RDX,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int IW = clog2(DATA_BITS + 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_rxs;
   rx_state_t              r_state;
   rx_state_t              w_state_next;
   logic                   w_clear;
   logic                   w_half;
   logic                   w_tick;
   logic                   w_deliver;
   logic                   w_accept;
   logic [IW-1:0]          r_bidx;
   logic                   r_scnt;
   logic [DATA_BITS-1:0]   r_shreg;
   logic                   r_perr;
   logic                   r_ferr;
   logic [DATA_BITS-1:0]   r_data;
   logic                   r_valid;
   logic                   r_parity_err;
   logic                   r_frame_err;
   logic                   r_overrun;

   assign w_rxs    = r_sync[SYNC_STAGES-1];
   assign w_accept = !r_valid || rx_ready;

   serial_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .i_clk   (m_clock),
      .i_srst  (p_reset),
      .i_clear (w_clear),
      .i_enable(!w_clear),
      .i_half  (w_half),
      .o_tick  (w_tick)
   );

   always_ff @(posedge m_clock) begin
      if (p_reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      w_half       = 1'b0;
      w_deliver    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_clear = 1'b1;
            if (!w_rxs) w_state_next = S_START;
         end
         S_START: begin
            w_half = 1'b1;
            if (w_tick) w_state_next = w_rxs ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (w_tick && (r_bidx == IW'(DATA_BITS - 1)))
               w_state_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (w_tick) w_state_next = S_STOP;
         end
         S_STOP: begin
            // Leaving mid-stop-bit lets the next start edge be caught early.
            if (w_tick && (r_scnt == 1'(STOP_BITS - 1))) begin
               w_deliver    = 1'b1;
               w_state_next = w_rxs ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            w_clear = 1'b1;
            if (w_rxs) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         r_sync       <= '1;
         r_bidx       <= '0;
         r_scnt       <= 1'b0;
         r_shreg      <= '0;
         r_perr       <= 1'b0;
         r_ferr       <= 1'b0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], RDX};
         r_overrun <= 1'b0;
         case (r_state)
            S_START: if (w_tick) begin
               r_bidx <= '0;
               r_scnt <= 1'b0;
               r_perr <= 1'b0;
               r_ferr <= 1'b0;
            end
            S_DATA: if (w_tick) begin
               r_shreg <= {w_rxs, r_shreg[DATA_BITS-1:1]};
               r_bidx  <= r_bidx + 1'b1;
            end
            S_PARITY: if (w_tick)
               r_perr <= (^r_shreg) ^ w_rxs ^ (PARITY == PAR_ODD);
            S_STOP: if (w_tick) begin
               r_scnt <= r_scnt + 1'b1;
               r_ferr <= r_ferr | !w_rxs;
            end
            default: ;
         endcase
         // A held, unconsumed word wins; the new frame is dropped and flagged.
         if (w_deliver) begin
            if (w_accept) begin
               r_data       <= r_shreg;
               r_parity_err <= r_perr;
               r_frame_err  <= r_ferr | !w_rxs;
               r_valid      <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data    = r_data;
   assign rx_valid   = r_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_rx_param.sv
// Bench for serial_rx_param: three 8-bit receivers (no/even/odd parity) at 16
// clocks per bit, table-driven frames plus hand-written corner sequences.
module tb_serial_rx_param;

   localparam int CPB = 16;

   typedef struct {
      int         k;
      logic [7:0] d;
      logic       pbit;
      logic [7:0] exp_d;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   typedef struct {
      int         k;
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk;
   logic       p_reset;
   logic       rx_ready;
   logic       rdx        [3];
   logic [7:0] rx_data    [3];
   logic       rx_valid   [3];
   logic       parity_err [3];
   logic       frame_err  [3];
   logic       overrun    [3];
   logic       busy       [3];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   words    [3] = '{0, 0, 0};
   int   last_cyc [3] = '{0, 0, 0};
   int   vcyc     [3] = '{0, 0, 0};
   int   ovr_cnt  [3] = '{0, 0, 0};
   int   ovr_cyc  [3] = '{0, 0, 0};
   logic prev_valid [3] = '{1'b0, 1'b0, 1'b0};
   logic prev_acc   [3] = '{1'b0, 1'b0, 1'b0};
   exp_t exp_q[$];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         serial_rx_param #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (8),
            .PARITY      (gi),
            .STOP_BITS   (1),
            .SYNC_STAGES (2)
         ) u_dut (
            .m_clock   (clk),
            .p_reset   (p_reset),
            .RDX       (rdx[gi]),
            .rx_data   (rx_data[gi]),
            .rx_valid  (rx_valid[gi]),
            .rx_ready  (rx_ready),
            .parity_err(parity_err[gi]),
            .frame_err (frame_err[gi]),
            .overrun   (overrun[gi]),
            .busy      (busy[gi])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Output monitor: detects each newly loaded word and compares it with the scoreboard.
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      #2;
      for (int k = 0; k < 3; k++) begin
         if (rx_valid[k] && (!prev_valid[k] || prev_acc[k])) begin
            words[k]++;
            last_cyc[k] = cyc;
            $display("word dut=%0d data=%02h perr=%0b ferr=%0b cycle=%0d",
                     k, rx_data[k], parity_err[k], frame_err[k], cyc);
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("word_dut", k, e.k);
               chk("rx_data", {24'd0, rx_data[k]}, {24'd0, e.d});
               chk("parity_err", {31'd0, parity_err[k]}, {31'd0, e.pe});
               chk("frame_err", {31'd0, frame_err[k]}, {31'd0, e.fe});
            end
         end
         if (rx_valid[k]) vcyc[k]++;
         if (overrun[k]) begin
            ovr_cnt[k]++;
            ovr_cyc[k] = cyc;
         end
         prev_valid[k] = rx_valid[k];
         prev_acc[k]   = rx_valid[k] && rx_ready;
      end
   end

   task automatic send_frame(input int k, input logic [7:0] d, input logic pbit,
                             input logic stopv, output int c0);
      @(negedge clk);
      rdx[k] = 1'b0;
      c0 = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rdx[k] = d[i];
         repeat (CPB) @(negedge clk);
      end
      if (k != 0) begin
         rdx[k] = pbit;
         repeat (CPB) @(negedge clk);
      end
      rdx[k] = stopv;
      repeat (CPB) @(negedge clk);
      if (stopv) rdx[k] = 1'b1;
   endtask

   task automatic wait_words(input int k, input int target, input string name);
      int n;
      n = 0;
      while (words[k] < target && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(name, words[k], target);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rx_data"}, {24'd0, rx_data[0]}, 32'd0);
      chk({tag, "_rx_valid"}, {31'd0, rx_valid[0]}, 32'd0);
      chk({tag, "_parity_err"}, {31'd0, parity_err[0]}, 32'd0);
      chk({tag, "_frame_err"}, {31'd0, frame_err[0]}, 32'd0);
      chk({tag, "_overrun"}, {31'd0, overrun[0]}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy[0]}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs [8];
      int   c0, c1, w0, vc0, o0;
      logic busy_seen;
      logic [7:0] part;

      vecs[0] = '{0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[2] = '{0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[3] = '{1, 8'h03, 1'b1, 8'h03, 1'b1, 1'b0};
      vecs[4] = '{1, 8'h03, 1'b0, 8'h03, 1'b0, 1'b0};
      vecs[5] = '{1, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0};
      vecs[6] = '{2, 8'h03, 1'b1, 8'h03, 1'b0, 1'b0};
      vecs[7] = '{2, 8'h80, 1'b1, 8'h80, 1'b1, 1'b0};

      p_reset  = 1'b1;
      rx_ready = 1'b1;
      for (int k = 0; k < 3; k++) rdx[k] = 1'b1;
      repeat (5) @(negedge clk);
      chk_reset_outputs("reset");
      p_reset = 1'b0;
      repeat (5) @(negedge clk);

      // Table-driven frames with latency and single-cycle valid checks.
      for (int i = 0; i < 8; i++) begin
         w0  = words[vecs[i].k];
         vc0 = vcyc[vecs[i].k];
         exp_q.push_back('{vecs[i].k, vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe});
         send_frame(vecs[i].k, vecs[i].d, vecs[i].pbit, 1'b1, c0);
         repeat (4) @(negedge clk);
         wait_words(vecs[i].k, w0 + 1, "vec_word_count");
         chk("vec_latency", last_cyc[vecs[i].k] - c0,
             2 + CPB / 2 + CPB * (8 + ((vecs[i].k != 0) ? 1 : 0) + 1) + 1);
         chk("vec_valid_cycles", vcyc[vecs[i].k] - vc0, 1);
      end

      // False start: short low pulse, then a good frame.
      w0 = words[0];
      busy_seen = 1'b0;
      @(negedge clk);
      rdx[0] = 1'b0;
      repeat (5) @(negedge clk);
      rdx[0] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         busy_seen = busy_seen | busy[0];
      end
      chk("false_start_busy_seen", {31'd0, busy_seen}, 32'd1);
      chk("false_start_no_word", words[0] - w0, 0);
      chk("false_start_idle", {31'd0, busy[0]}, 32'd0);
      exp_q.push_back('{0, 8'h5A, 1'b0, 1'b0});
      send_frame(0, 8'h5A, 1'b0, 1'b1, c0);
      wait_words(0, w0 + 1, "after_false_start_word");

      // Stop bit low and line held low: one framing-error word, busy in BREAK.
      w0 = words[0];
      exp_q.push_back('{0, 8'h3C, 1'b0, 1'b1});
      send_frame(0, 8'h3C, 1'b0, 1'b0, c0);
      repeat (100) @(negedge clk);
      chk("break_busy", {31'd0, busy[0]}, 32'd1);
      chk("break_word_count", words[0] - w0, 1);
      chk("break_latency", last_cyc[0] - c0, 155);
      rdx[0] = 1'b1;
      repeat (6) @(negedge clk);
      chk("break_release_idle", {31'd0, busy[0]}, 32'd0);
      repeat (40) @(negedge clk);
      chk("break_no_second_word", words[0] - w0, 1);

      // Overrun: consumer stalled across two frames.
      rx_ready = 1'b0;
      w0 = words[0];
      o0 = ovr_cnt[0];
      exp_q.push_back('{0, 8'h11, 1'b0, 1'b0});
      send_frame(0, 8'h11, 1'b0, 1'b1, c0);
      chk("hold_valid", {31'd0, rx_valid[0]}, 32'd1);
      send_frame(0, 8'h22, 1'b0, 1'b1, c1);
      repeat (4) @(negedge clk);
      chk("overrun_pulse_cycles", ovr_cnt[0] - o0, 1);
      chk("overrun_timing", ovr_cyc[0] - c1, 155);
      chk("hold_rx_data", {24'd0, rx_data[0]}, 32'h11);
      chk("hold_valid_after", {31'd0, rx_valid[0]}, 32'd1);
      chk("overrun_word_count", words[0] - w0, 1);
      rx_ready = 1'b1;
      @(posedge clk);
      #2;
      chk("ready_clears_valid", {31'd0, rx_valid[0]}, 32'd0);

      // Reset in the middle of data bit 4 while a word is held.
      @(negedge clk);
      rx_ready = 1'b0;
      exp_q.push_back('{0, 8'h77, 1'b0, 1'b0});
      send_frame(0, 8'h77, 1'b0, 1'b1, c0);
      chk("pre_reset_valid", {31'd0, rx_valid[0]}, 32'd1);
      part = 8'h0F;
      rdx[0] = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rdx[0] = part[i];
         repeat (CPB) @(negedge clk);
      end
      rdx[0] = part[4];
      repeat (CPB / 2) @(negedge clk);
      chk("pre_reset_busy", {31'd0, busy[0]}, 32'd1);
      p_reset = 1'b1;
      rdx[0]  = 1'b1;
      @(posedge clk);
      #2;
      chk_reset_outputs("midframe_reset");
      @(negedge clk);
      p_reset  = 1'b0;
      rx_ready = 1'b1;
      w0 = words[0];
      repeat (200) @(negedge clk);
      chk("reset_no_delivery", words[0] - w0, 0);
      exp_q.push_back('{0, 8'hC3, 1'b0, 1'b0});
      send_frame(0, 8'hC3, 1'b0, 1'b1, c0);
      wait_words(0, w0 + 1, "after_reset_word");
      chk("after_reset_latency", last_cyc[0] - c0, 155);

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
